// File: rtl/branch_sequencer.sv
// ---------------------------------------------------------------------------
// branch_sequencer
//
// Sub-sequencer for the conditional branch instructions (brzr/brnz/brpl/brmi).
// Main control pulses Start. The block then walks the datapath through five
// microsteps:
//   RA  : put R[ra] on the bus
//   CON : hold the bus and strobe the CON flip-flop
//   PC  : PC -> Y
//   OFF : Y + C -> Z
//   WB  : Z -> PC, but only when the CON flip-flop reported "condition met"
// It also keeps saturating branch statistics for debug readout.
//
// Every control output is a flop that loads on the same edge as the state
// register. The outputs are therefore glitch-free, and each one is valid for
// exactly the cycle its state occupies.
//
// Parameters
//   CNT_W   width of the statistics counters
//   ADD_OP  ALU opcode driven during the offset-add step
//
// Ports
//   clock        in   system clock, rising-edge active
//   reset        in   synchronous, active-high; clears FSM, outputs, counters
//   Start        in   one-cycle request from main control (sampled in IDLE)
//   ConFFOut     in   CON flip-flop result (1 = branch condition met)
//   Gra          out  select R[ra] via the IR ra field
//   Rout         out  drive the selected register onto the bus
//   ConIn        out  CON flip-flop evaluate strobe
//   PCout        out  drive PC onto the bus
//   Yin          out  load Y
//   Cout         out  drive the sign-extended C field onto the bus
//   AluOp        out  ALU operation (ADD_OP in OFF, else 0)
//   Zin          out  load Z
//   ZLowout      out  drive Z[31:0] onto the bus
//   PCin         out  load PC from the bus
//   Busy         out  high whenever the FSM is not idle
//   Done         out  one-cycle completion pulse
//   Taken        out  outcome of the last completed branch
//   BranchCount  out  completed branches, saturating
//   TakenCount   out  completed taken branches, saturating
// ---------------------------------------------------------------------------
module branch_sequencer #(
   parameter int         CNT_W  = 16,
   parameter logic [4:0] ADD_OP = 5'b00011
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             Start,
   input  logic             ConFFOut,
   output logic             Gra,
   output logic             Rout,
   output logic             ConIn,
   output logic             PCout,
   output logic             Yin,
   output logic             Cout,
   output logic [4:0]       AluOp,
   output logic             Zin,
   output logic             ZLowout,
   output logic             PCin,
   output logic             Busy,
   output logic             Done,
   output logic             Taken,
   output logic [CNT_W-1:0] BranchCount,
   output logic [CNT_W-1:0] TakenCount
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RA   = 3'd1;
   localparam logic [2:0] S_CON  = 3'd2;
   localparam logic [2:0] S_PC   = 3'd3;
   localparam logic [2:0] S_OFF  = 3'd4;
   localparam logic [2:0] S_WB   = 3'd5;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) begin
         return v;
      end
      return v + CNT_W'(1);
   endfunction

   logic [2:0]       state_q,   state_d;
   logic             gra_q,     gra_d;
   logic             rout_q,    rout_d;
   logic             conin_q,   conin_d;
   logic             pcout_q,   pcout_d;
   logic             yin_q,     yin_d;
   logic             cout_q,    cout_d;
   logic [4:0]       aluop_q,   aluop_d;
   logic             zin_q,     zin_d;
   logic             zlowout_q, zlowout_d;
   logic             pcin_q,    pcin_d;
   logic             busy_q,    busy_d;
   logic             done_q,    done_d;
   logic             taken_q,   taken_d;
   logic [CNT_W-1:0] bcnt_q,    bcnt_d;
   logic [CNT_W-1:0] tcnt_q,    tcnt_d;
   logic             finish;

   // Next state. Start matters only in IDLE. Requests that arrive mid-sequence
   // are dropped, not queued.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = Start ? S_RA : S_IDLE;
         S_RA:    state_d = S_CON;
         S_CON:   state_d = S_PC;
         S_PC:    state_d = S_OFF;
         S_OFF:   state_d = S_WB;
         S_WB:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the *next* state, so they register together with
   // the state. ConIn thus rises one full cycle after R[ra] first reaches the
   // bus.
   always_comb begin
      gra_d     = 1'b0;
      rout_d    = 1'b0;
      conin_d   = 1'b0;
      pcout_d   = 1'b0;
      yin_d     = 1'b0;
      cout_d    = 1'b0;
      aluop_d   = 5'd0;
      zin_d     = 1'b0;
      zlowout_d = 1'b0;
      pcin_d    = 1'b0;
      case (state_d)
         S_RA: begin
            gra_d  = 1'b1;
            rout_d = 1'b1;
         end
         S_CON: begin
            gra_d   = 1'b1;
            rout_d  = 1'b1;
            conin_d = 1'b1;
         end
         S_PC: begin
            pcout_d = 1'b1;
            yin_d   = 1'b1;
         end
         S_OFF: begin
            cout_d  = 1'b1;
            aluop_d = ADD_OP;
            zin_d   = 1'b1;
         end
         S_WB: begin
            // The condition is captured on the edge entering WB. A not-taken
            // branch leaves PC alone, because fetch already advanced it.
            zlowout_d = 1'b1;
            pcin_d    = ConFFOut;
         end
         default: ;
      endcase
   end

   // Completion bookkeeping happens on the WB -> IDLE edge.
   assign finish  = (state_q == S_WB);
   assign busy_d  = (state_d != S_IDLE);
   assign done_d  = finish;
   assign taken_d = finish ? pcin_q : taken_q;
   assign bcnt_d  = finish ? sat_inc(bcnt_q) : bcnt_q;
   assign tcnt_d  = (finish && pcin_q) ? sat_inc(tcnt_q) : tcnt_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         gra_q     <= 1'b0;
         rout_q    <= 1'b0;
         conin_q   <= 1'b0;
         pcout_q   <= 1'b0;
         yin_q     <= 1'b0;
         cout_q    <= 1'b0;
         aluop_q   <= 5'd0;
         zin_q     <= 1'b0;
         zlowout_q <= 1'b0;
         pcin_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         taken_q   <= 1'b0;
         bcnt_q    <= '0;
         tcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         gra_q     <= gra_d;
         rout_q    <= rout_d;
         conin_q   <= conin_d;
         pcout_q   <= pcout_d;
         yin_q     <= yin_d;
         cout_q    <= cout_d;
         aluop_q   <= aluop_d;
         zin_q     <= zin_d;
         zlowout_q <= zlowout_d;
         pcin_q    <= pcin_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         taken_q   <= taken_d;
         bcnt_q    <= bcnt_d;
         tcnt_q    <= tcnt_d;
      end
   end

   assign Gra         = gra_q;
   assign Rout        = rout_q;
   assign ConIn       = conin_q;
   assign PCout       = pcout_q;
   assign Yin         = yin_q;
   assign Cout        = cout_q;
   assign AluOp       = aluop_q;
   assign Zin         = zin_q;
   assign ZLowout     = zlowout_q;
   assign PCin        = pcin_q;
   assign Busy        = busy_q;
   assign Done        = done_q;
   assign Taken       = taken_q;
   assign BranchCount = bcnt_q;
   assign TakenCount  = tcnt_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Testbench for branch_sequencer. Two instances share stimulus: one with
// 16-bit counters and one with 2-bit counters, so saturation is reachable.
// The reference model tracks the edge at which the current branch was
// accepted. It derives each cycle's outputs from the offset to that edge,
// using the published timing table.
module tb_branch_sequencer;

   localparam logic [4:0] ADD_OP = 5'b00011;

   logic clock;
   logic reset, Start, ConFFOut;

   logic        Gra, Rout, ConIn, PCout, Yin, Cout, Zin, ZLowout, PCin, Busy, Done, Taken;
   logic [4:0]  AluOp;
   logic [15:0] BranchCount, TakenCount;

   logic        Gra_s, Rout_s, ConIn_s, PCout_s, Yin_s, Cout_s, Zin_s, ZLowout_s, PCin_s, Busy_s, Done_s, Taken_s;
   logic [4:0]  AluOp_s;
   logic [1:0]  BranchCount_s, TakenCount_s;

   branch_sequencer #(.CNT_W(16), .ADD_OP(ADD_OP)) dut (
      .clock(clock), .reset(reset), .Start(Start), .ConFFOut(ConFFOut),
      .Gra(Gra), .Rout(Rout), .ConIn(ConIn), .PCout(PCout), .Yin(Yin), .Cout(Cout),
      .AluOp(AluOp), .Zin(Zin), .ZLowout(ZLowout), .PCin(PCin), .Busy(Busy),
      .Done(Done), .Taken(Taken), .BranchCount(BranchCount), .TakenCount(TakenCount)
   );

   branch_sequencer #(.CNT_W(2), .ADD_OP(ADD_OP)) dut_s (
      .clock(clock), .reset(reset), .Start(Start), .ConFFOut(ConFFOut),
      .Gra(Gra_s), .Rout(Rout_s), .ConIn(ConIn_s), .PCout(PCout_s), .Yin(Yin_s), .Cout(Cout_s),
      .AluOp(AluOp_s), .Zin(Zin_s), .ZLowout(ZLowout_s), .PCin(PCin_s), .Busy(Busy_s),
      .Done(Done_s), .Taken(Taken_s), .BranchCount(BranchCount_s), .TakenCount(TakenCount_s)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- reference model ----------------
   int  cyc      = 0;        // index of the next rising edge
   int  acc_edge = -1000;    // edge at which the current/last branch was accepted
   bit  m_cond   = 0;        // condition captured at accept+4
   bit  m_taken  = 0;
   int  m_bc = 0, m_tc = 0, m_bcs = 0, m_tcs = 0;
   logic [16:0] exp_ctrl;
   bit  m_in_off;

   wire [16:0] ctrl_a = {Gra, Rout, ConIn, PCout, Yin, Cout, AluOp, Zin, ZLowout, PCin, Busy, Done, Taken};
   wire [16:0] ctrl_b = {Gra_s, Rout_s, ConIn_s, PCout_s, Yin_s, Cout_s, AluOp_s, Zin_s, ZLowout_s,
                         PCin_s, Busy_s, Done_s, Taken_s};
   wire [69:0] obs = {ctrl_a, ctrl_b, BranchCount, TakenCount, BranchCount_s, TakenCount_s};
   logic [69:0] exp_vec;

   function automatic int sat(input int v, input int maxv);
      return (v >= maxv) ? maxv : v + 1;
   endfunction

   // Advance one clock edge. Update the model from the inputs seen at that
   // edge, then wait to the falling edge so the outputs can be sampled.
   task automatic step();
      int d;
      @(posedge clock);
      if (reset) begin
         acc_edge = -1000;
         m_taken  = 0;
         m_cond   = 0;
         m_bc = 0; m_tc = 0; m_bcs = 0; m_tcs = 0;
      end else begin
         d = cyc - acc_edge;
         if (d == 4) m_cond = ConFFOut;
         if (d == 5) begin
            m_taken = m_cond;
            m_bc  = sat(m_bc, 65535);
            m_bcs = sat(m_bcs, 3);
            if (m_cond) begin
               m_tc  = sat(m_tc, 65535);
               m_tcs = sat(m_tcs, 3);
            end
         end
         if (Start && (cyc - acc_edge >= 6)) acc_edge = cyc;
      end
      d = cyc - acc_edge;
      // Gra Rout ConIn PCout Yin Cout AluOp Zin ZLowout PCin Busy Done Taken
      case (d)
         0: exp_ctrl = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,   1'b0, 1'b0, 1'b0,   1'b1, 1'b0, m_taken};
         1: exp_ctrl = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,   1'b0, 1'b0, 1'b0,   1'b1, 1'b0, m_taken};
         2: exp_ctrl = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0,   1'b0, 1'b0, 1'b0,   1'b1, 1'b0, m_taken};
         3: exp_ctrl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ADD_OP, 1'b1, 1'b0, 1'b0,   1'b1, 1'b0, m_taken};
         4: exp_ctrl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,   1'b0, 1'b1, m_cond, 1'b1, 1'b0, m_taken};
         5: exp_ctrl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,   1'b0, 1'b0, 1'b0,   1'b0, 1'b1, m_taken};
         default: exp_ctrl = {16'd0, m_taken};
      endcase
      m_in_off = (d == 3);
      exp_vec = {exp_ctrl, exp_ctrl, 16'(m_bc), 16'(m_tc), 2'(m_bcs), 2'(m_tcs)};
      cyc++;
      @(negedge clock);
   endtask

   // Bus-driver exclusivity and the AluOp rule, checked every cycle.
   bit chk_en = 0;
   always @(negedge clock) begin
      if (chk_en) begin
         n_tests++;
         if ((int'(Rout) + int'(PCout) + int'(Cout) + int'(ZLowout)) > 1) begin
            n_fail++;
            $display("FAIL bus_excl t=%0t drivers R/PC/C/Z=%b%b%b%b required at most one", $time, Rout, PCout, Cout, ZLowout);
         end
         n_tests++;
         if (!m_in_off && AluOp !== 5'd0) begin
            n_fail++;
            $display("FAIL aluop_idle t=%0t AluOp=%h required 0", $time, AluOp);
         end
      end
   end

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1; Start = 0; ConFFOut = 0;
      step(); step();
      chk_en = 1;
      n_tests++;
      if (obs !== exp_vec) begin
         n_fail++;
         $display("FAIL reset obs=%h required=%h", obs, exp_vec);
      end
      n_tests++;
      if (Busy !== 1'b0 || BranchCount !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_busy Busy=%b BranchCount=%0d required 0/0", Busy, BranchCount);
      end
      reset = 0;
      step();
   endtask

   task automatic test_taken();
      int n_conin = 0, n_pcin = 0, done_at = -1;
      Start = 1; ConFFOut = 1;
      for (int i = 0; i < 8; i++) begin
         step();
         Start = 0;
         n_tests++;
         if (obs !== exp_vec) begin
            n_fail++;
            $display("FAIL taken cyc=%0d obs=%h required=%h", i, obs, exp_vec);
         end
         if (ConIn) n_conin++;
         if (PCin)  n_pcin++;
         if (ConIn && i != 1) n_conin += 10;
         if (PCin  && i != 4) n_pcin  += 10;
         if (Done) done_at = i;
      end
      n_tests++;
      if (n_conin != 1 || n_pcin != 1 || done_at != 5) begin
         n_fail++;
         $display("FAIL taken_strobes conin=%0d pcin=%0d done_at=%0d required 1/1/5", n_conin, n_pcin, done_at);
      end
      n_tests++;
      if (Taken !== 1'b1 || BranchCount !== 16'd1 || TakenCount !== 16'd1) begin
         n_fail++;
         $display("FAIL taken_stats Taken=%b BC=%0d TC=%0d required 1/1/1", Taken, BranchCount, TakenCount);
      end
   endtask

   task automatic test_not_taken();
      int n_pcin = 0;
      Start = 1; ConFFOut = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         Start = 0;
         n_tests++;
         if (obs !== exp_vec) begin
            n_fail++;
            $display("FAIL not_taken cyc=%0d obs=%h required=%h", i, obs, exp_vec);
         end
         if (PCin) n_pcin++;
      end
      n_tests++;
      if (n_pcin != 0 || Taken !== 1'b0 || BranchCount !== 16'd2 || TakenCount !== 16'd1) begin
         n_fail++;
         $display("FAIL not_taken_stats pcin=%0d Taken=%b BC=%0d TC=%0d required 0/0/2/1",
                  n_pcin, Taken, BranchCount, TakenCount);
      end
   endtask

   task automatic test_start_held();
      int n_done = 0, first_ra = -1, second_ra = -1;
      ConFFOut = 0;
      for (int i = 0; i < 16; i++) begin
         Start = (i < 8);
         step();
         n_tests++;
         if (obs !== exp_vec) begin
            n_fail++;
            $display("FAIL start_held cyc=%0d obs=%h required=%h", i, obs, exp_vec);
         end
         if (Done) n_done++;
         if (Gra && !ConIn) begin
            if (first_ra < 0) first_ra = i;
            else if (second_ra < 0) second_ra = i;
         end
      end
      Start = 0;
      n_tests++;
      if (n_done != 2 || first_ra != 0 || second_ra != 6 || BranchCount !== 16'd4) begin
         n_fail++;
         $display("FAIL start_held_seq done=%0d ra=%0d,%0d BC=%0d required 2 0,6 4",
                  n_done, first_ra, second_ra, BranchCount);
      end
   endtask

   task automatic test_reset_mid();
      Start = 1; ConFFOut = 1;
      step();                 // accepted: RA
      Start = 0;
      step(); step(); step(); // CON, PC, OFF
      n_tests++;
      if (Cout !== 1'b1 || AluOp !== ADD_OP) begin
         n_fail++;
         $display("FAIL reset_mid_off Cout=%b AluOp=%h required 1/%h", Cout, AluOp, ADD_OP);
      end
      reset = 1;
      step();
      n_tests++;
      if (obs !== exp_vec || obs !== 70'd0) begin
         n_fail++;
         $display("FAIL reset_mid obs=%h required=%h", obs, exp_vec);
      end
      reset = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         n_tests++;
         if (obs !== exp_vec) begin
            n_fail++;
            $display("FAIL reset_mid_after cyc=%0d obs=%h required=%h", i, obs, exp_vec);
         end
      end
   endtask

   task automatic test_saturation();
      int n_done = 0;
      ConFFOut = 1;
      for (int i = 0; i < 32; i++) begin
         Start = (i < 25);
         step();
         n_tests++;
         if (obs !== exp_vec) begin
            n_fail++;
            $display("FAIL saturation cyc=%0d obs=%h required=%h", i, obs, exp_vec);
         end
         if (Done_s) n_done++;
      end
      Start = 0;
      n_tests++;
      if (n_done != 5 || BranchCount_s !== 2'd3 || TakenCount_s !== 2'd3 || BranchCount !== 16'd5) begin
         n_fail++;
         $display("FAIL saturation_stats done=%0d BCs=%0d TCs=%0d BC=%0d required 5/3/3/5",
                  n_done, BranchCount_s, TakenCount_s, BranchCount);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 500; i++) begin
         Start    = ($urandom_range(0, 2) == 0);
         ConFFOut = $urandom_range(0, 1) == 1;
         reset    = ($urandom_range(0, 79) == 0);
         step();
         n_tests++;
         if (obs !== exp_vec) begin
            n_fail++;
            $display("FAIL random cyc=%0d obs=%h required=%h", i, obs, exp_vec);
         end
      end
      reset = 0; Start = 0;
   endtask

   initial begin
      reset = 1; Start = 0; ConFFOut = 0;
      test_reset();
      test_taken();
      test_not_taken();
      test_start_held();
      test_reset_mid();
      test_saturation();
      test_random();
      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
